// File: rtl/fp_align64.sv
// fp_align64 -- FP64 add/subtract front-end aligner (3-stage pipeline).
//
// Unpacks two binary64 operands, orders them by exponent and right-shifts the
// smaller significand by the exponent difference, collecting guard/round/
// sticky. Output significands are 57 bits:
//   [56] carry headroom (0), [55] hidden, [54:3] fraction, [2] G, [1] R, [0] S.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset (overrides ce)
//   ce            clock enable; low freezes every register, valid pipe included
//   valid_i       operand pair valid this cycle
//   a, b          packed FP64 operands
//   valid_o       aligned result valid (3 enabled cycles after valid_i)
//   xo            common (larger) exponent, 0x7FF if either operand is NaN/Inf
//   ma, mb        large-operand significand / aligned small-operand significand
//   sa, sb        signs of the ma / mb operands
//   swap_o        1 = ma came from input b
//   nan_o, inf_o, zero_o  class flags, bit0 = ma operand, bit1 = mb operand
//
// Build option: FP64_ALIGN_DENORMALS_EN
//   defined   -> exp=0 operands keep their fraction (hidden 0, exponent 1)
//   undefined -> exp=0 operands flush to zero (exponent 0, zero flag set)

module fp_align64 (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce,
    input  logic        valid_i,
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        valid_o,
    output logic [10:0] xo,
    output logic [56:0] ma,
    output logic [56:0] mb,
    output logic        sa,
    output logic        sb,
    output logic        swap_o,
    output logic [1:0]  nan_o,
    output logic [1:0]  inf_o,
    output logic [1:0]  zero_o
);

    localparam logic [10:0] EXP_MAX   = 11'h7FF;
    localparam logic [11:0] SHIFT_MAX = 12'd56;

    // ------------------------------------------------------------------
    // Valid pipeline
    // ------------------------------------------------------------------
    logic [2:0] vld_d, vld_q;

    always_comb begin
        vld_d = {vld_q[1:0], valid_i};
    end

    // ------------------------------------------------------------------
    // Stage 1: unpack and classify (flag bit0 = a, bit1 = b)
    // ------------------------------------------------------------------
    logic        s1_sa_d,   s1_sa_q;
    logic        s1_sb_d,   s1_sb_q;
    logic [10:0] s1_ea_d,   s1_ea_q;
    logic [10:0] s1_eb_d,   s1_eb_q;
    logic [56:0] s1_ma_d,   s1_ma_q;
    logic [56:0] s1_mb_d,   s1_mb_q;
    logic [1:0]  s1_nan_d,  s1_nan_q;
    logic [1:0]  s1_inf_d,  s1_inf_q;
    logic [1:0]  s1_zero_d, s1_zero_q;
    logic [11:0] s1_dab_d,  s1_dab_q;
    logic [11:0] s1_dba_d,  s1_dba_q;

    logic [10:0] exp_a, exp_b;
    logic [51:0] frac_a, frac_b;

    always_comb begin
        exp_a  = a[62:52];
        exp_b  = b[62:52];
        frac_a = a[51:0];
        frac_b = b[51:0];

        s1_sa_d = a[63];
        s1_sb_d = b[63];

        s1_nan_d[0] = (exp_a == EXP_MAX) && (frac_a != '0);
        s1_nan_d[1] = (exp_b == EXP_MAX) && (frac_b != '0);
        s1_inf_d[0] = (exp_a == EXP_MAX) && (frac_a == '0);
        s1_inf_d[1] = (exp_b == EXP_MAX) && (frac_b == '0);

`ifdef FP64_ALIGN_DENORMALS_EN
        s1_ea_d      = (exp_a == '0) ? 11'd1 : exp_a;
        s1_eb_d      = (exp_b == '0) ? 11'd1 : exp_b;
        s1_ma_d      = {1'b0, (exp_a != '0), frac_a, 3'b000};
        s1_mb_d      = {1'b0, (exp_b != '0), frac_b, 3'b000};
        s1_zero_d[0] = (exp_a == '0) && (frac_a == '0);
        s1_zero_d[1] = (exp_b == '0) && (frac_b == '0);
`else
        s1_ea_d      = exp_a;
        s1_eb_d      = exp_b;
        s1_zero_d[0] = (exp_a == '0);
        s1_zero_d[1] = (exp_b == '0);
        s1_ma_d      = s1_zero_d[0] ? '0 : {2'b01, frac_a, 3'b000};
        s1_mb_d      = s1_zero_d[1] ? '0 : {2'b01, frac_b, 3'b000};
`endif

        s1_dab_d = {1'b0, s1_ea_d} - {1'b0, s1_eb_d};
        s1_dba_d = {1'b0, s1_eb_d} - {1'b0, s1_ea_d};
    end

    // ------------------------------------------------------------------
    // Stage 2: order by exponent, compute clamped shift amount
    // ------------------------------------------------------------------
    logic [10:0] s2_xo_d,   s2_xo_q;
    logic [56:0] s2_ma_d,   s2_ma_q;
    logic [56:0] s2_mb_d,   s2_mb_q;
    logic        s2_sa_d,   s2_sa_q;
    logic        s2_sb_d,   s2_sb_q;
    logic        s2_swap_d, s2_swap_q;
    logic [1:0]  s2_nan_d,  s2_nan_q;
    logic [1:0]  s2_inf_d,  s2_inf_q;
    logic [1:0]  s2_zero_d, s2_zero_q;
    logic [5:0]  s2_sh_d,   s2_sh_q;

    logic        special;
    logic [11:0] diff;

    always_comb begin
        // Strict compare: equal exponents keep a as the large operand.
        s2_swap_d = (s1_eb_q > s1_ea_q);
        special   = (|s1_nan_q) | (|s1_inf_q);
        diff      = s2_swap_d ? s1_dba_q : s1_dab_q;

        if (special) begin
            s2_sh_d = '0;
        end else if (diff > SHIFT_MAX) begin
            s2_sh_d = SHIFT_MAX[5:0];
        end else begin
            s2_sh_d = diff[5:0];
        end

        if (special) begin
            s2_xo_d = EXP_MAX;
        end else begin
            s2_xo_d = s2_swap_d ? s1_eb_q : s1_ea_q;
        end

        if (s2_swap_d) begin
            s2_ma_d   = s1_mb_q;
            s2_mb_d   = s1_ma_q;
            s2_sa_d   = s1_sb_q;
            s2_sb_d   = s1_sa_q;
            s2_nan_d  = {s1_nan_q[0],  s1_nan_q[1]};
            s2_inf_d  = {s1_inf_q[0],  s1_inf_q[1]};
            s2_zero_d = {s1_zero_q[0], s1_zero_q[1]};
        end else begin
            s2_ma_d   = s1_ma_q;
            s2_mb_d   = s1_mb_q;
            s2_sa_d   = s1_sa_q;
            s2_sb_d   = s1_sb_q;
            s2_nan_d  = s1_nan_q;
            s2_inf_d  = s1_inf_q;
            s2_zero_d = s1_zero_q;
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: shift small significand with sticky collection
    // ------------------------------------------------------------------
    logic [10:0] xo_d,   xo_q;
    logic [56:0] ma_d,   ma_q;
    logic [56:0] mb_d,   mb_q;
    logic        sa_d,   sa_q;
    logic        sb_d,   sb_q;
    logic        swap_d, swap_q;
    logic [1:0]  nan_d,  nan_q;
    logic [1:0]  inf_d,  inf_q;
    logic [1:0]  zero_d, zero_q;

    logic [56:0] ones;
    logic [56:0] lost_mask;
    logic [56:0] shifted;
    logic        lost;

    always_comb begin
        ones      = '1;
        shifted   = s2_mb_q >> s2_sh_q;
        // Bits below the shift amount are the ones pushed out; bit 56 is
        // always 0, so a shift of 56 leaves exactly OR(significand) in [0].
        lost_mask = ~(ones << s2_sh_q);
        lost      = |(s2_mb_q & lost_mask);
        mb_d      = {shifted[56:1], shifted[0] | lost | s2_mb_q[0]};

        xo_d   = s2_xo_q;
        ma_d   = s2_ma_q;
        sa_d   = s2_sa_q;
        sb_d   = s2_sb_q;
        swap_d = s2_swap_q;
        nan_d  = s2_nan_q;
        inf_d  = s2_inf_q;
        zero_d = s2_zero_q;
    end

    // ------------------------------------------------------------------
    // Registers: reset over ce, ce freezes everything
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q     <= '0;
            s1_sa_q   <= '0;
            s1_sb_q   <= '0;
            s1_ea_q   <= '0;
            s1_eb_q   <= '0;
            s1_ma_q   <= '0;
            s1_mb_q   <= '0;
            s1_nan_q  <= '0;
            s1_inf_q  <= '0;
            s1_zero_q <= '0;
            s1_dab_q  <= '0;
            s1_dba_q  <= '0;
            s2_xo_q   <= '0;
            s2_ma_q   <= '0;
            s2_mb_q   <= '0;
            s2_sa_q   <= '0;
            s2_sb_q   <= '0;
            s2_swap_q <= '0;
            s2_nan_q  <= '0;
            s2_inf_q  <= '0;
            s2_zero_q <= '0;
            s2_sh_q   <= '0;
            xo_q      <= '0;
            ma_q      <= '0;
            mb_q      <= '0;
            sa_q      <= '0;
            sb_q      <= '0;
            swap_q    <= '0;
            nan_q     <= '0;
            inf_q     <= '0;
            zero_q    <= '0;
        end else if (ce) begin
            vld_q     <= vld_d;
            s1_sa_q   <= s1_sa_d;
            s1_sb_q   <= s1_sb_d;
            s1_ea_q   <= s1_ea_d;
            s1_eb_q   <= s1_eb_d;
            s1_ma_q   <= s1_ma_d;
            s1_mb_q   <= s1_mb_d;
            s1_nan_q  <= s1_nan_d;
            s1_inf_q  <= s1_inf_d;
            s1_zero_q <= s1_zero_d;
            s1_dab_q  <= s1_dab_d;
            s1_dba_q  <= s1_dba_d;
            s2_xo_q   <= s2_xo_d;
            s2_ma_q   <= s2_ma_d;
            s2_mb_q   <= s2_mb_d;
            s2_sa_q   <= s2_sa_d;
            s2_sb_q   <= s2_sb_d;
            s2_swap_q <= s2_swap_d;
            s2_nan_q  <= s2_nan_d;
            s2_inf_q  <= s2_inf_d;
            s2_zero_q <= s2_zero_d;
            s2_sh_q   <= s2_sh_d;
            xo_q      <= xo_d;
            ma_q      <= ma_d;
            mb_q      <= mb_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            swap_q    <= swap_d;
            nan_q     <= nan_d;
            inf_q     <= inf_d;
            zero_q    <= zero_d;
        end
    end

    assign valid_o = vld_q[2];
    assign xo      = xo_q;
    assign ma      = ma_q;
    assign mb      = mb_q;
    assign sa      = sa_q;
    assign sb      = sb_q;
    assign swap_o  = swap_q;
    assign nan_o   = nan_q;
    assign inf_o   = inf_q;
    assign zero_o  = zero_q;

endmodule

// File: tb/tb_fp_align64.sv
// Self-checking bench for fp_align64: directed cases with constant
// expectations plus a scoreboard fed by an independent behavioural model.

module tb_fp_align64;

    typedef struct packed {
        logic [10:0] xo;
        logic [56:0] ma;
        logic [56:0] mb;
        logic        sa;
        logic        sb;
        logic        swap;
        logic [1:0]  nan;
        logic [1:0]  inf;
        logic [1:0]  zero;
    } res_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce;
    logic        valid_i;
    logic [63:0] a;
    logic [63:0] b;
    logic        valid_o;
    logic [10:0] xo;
    logic [56:0] ma;
    logic [56:0] mb;
    logic        sa;
    logic        sb;
    logic        swap_o;
    logic [1:0]  nan_o;
    logic [1:0]  inf_o;
    logic [1:0]  zero_o;

    int checks = 0;
    int errors = 0;
    res_t exp_q[$];

    localparam logic [63:0] ONE = 64'h3FF0000000000000;

    fp_align64 dut (
        .clk     (clk),
        .rst     (rst),
        .ce      (ce),
        .valid_i (valid_i),
        .a       (a),
        .b       (b),
        .valid_o (valid_o),
        .xo      (xo),
        .ma      (ma),
        .mb      (mb),
        .sa      (sa),
        .sb      (sb),
        .swap_o  (swap_o),
        .nan_o   (nan_o),
        .inf_o   (inf_o),
        .zero_o  (zero_o)
    );

    always #5 clk = ~clk;

    // Behavioural reference: unpack each operand, pick the larger exponent,
    // then shift one bit at a time accumulating the lost bits.
    function automatic res_t model(input logic [63:0] x, input logic [63:0] y);
        logic [63:0] op;
        logic [56:0] m [2];
        int          e [2];
        logic        s [2];
        logic        n [2];
        logic        f [2];
        logic        z [2];
        int          big;
        int          sml;
        int          d;
        logic        lost;
        logic        bit0;
        logic        spec;
        res_t        r;
        for (int k = 0; k < 2; k++) begin
            op   = (k == 0) ? x : y;
            s[k] = op[63];
            n[k] = (op[62:52] == 11'h7FF) && (op[51:0] != 52'd0);
            f[k] = (op[62:52] == 11'h7FF) && (op[51:0] == 52'd0);
            if (op[62:52] != 11'd0) begin
                e[k] = int'(op[62:52]);
                m[k] = {2'b01, op[51:0], 3'b000};
                z[k] = 1'b0;
            end else begin
`ifdef FP64_ALIGN_DENORMALS_EN
                e[k] = 1;
                m[k] = {2'b00, op[51:0], 3'b000};
                z[k] = (op[51:0] == 52'd0);
`else
                e[k] = 0;
                m[k] = '0;
                z[k] = 1'b1;
`endif
            end
        end
        big  = (e[1] > e[0]) ? 1 : 0;
        sml  = 1 - big;
        spec = n[0] | n[1] | f[0] | f[1];
        d    = e[big] - e[sml];
        if (d > 56) d = 56;
        if (spec) d = 0;
        r.mb = m[sml];
        bit0 = r.mb[0];
        lost = 1'b0;
        for (int i = 0; i < d; i++) begin
            lost = lost | r.mb[0];
            r.mb = r.mb >> 1;
        end
        r.mb[0] = r.mb[0] | lost | bit0;
        r.ma   = m[big];
        r.xo   = spec ? 11'h7FF : 11'(e[big]);
        r.sa   = s[big];
        r.sb   = s[sml];
        r.swap = (big == 1);
        r.nan  = {n[sml], n[big]};
        r.inf  = {f[sml], f[big]};
        r.zero = {z[sml], z[big]};
        return r;
    endfunction

    // Scoreboard consumer: an output is taken when it is valid and the
    // pipeline will advance on the next edge.
    always @(negedge clk) begin
        res_t e;
        res_t g;
        if (!rst && ce && valid_o) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra: valid_o high with nothing expected (xo=%h mb=%h)", xo, mb);
            end else begin
                e = exp_q.pop_front();
                g.xo = xo; g.ma = ma; g.mb = mb; g.sa = sa; g.sb = sb;
                g.swap = swap_o; g.nan = nan_o; g.inf = inf_o; g.zero = zero_o;
                if (g !== e) begin
                    errors++;
                    $display("FAIL sb_result: got xo=%h ma=%h mb=%h sa=%b sb=%b swap=%b nan=%b inf=%b zero=%b expected xo=%h ma=%h mb=%h sa=%b sb=%b swap=%b nan=%b inf=%b zero=%b",
                             g.xo, g.ma, g.mb, g.sa, g.sb, g.swap, g.nan, g.inf, g.zero,
                             e.xo, e.ma, e.mb, e.sa, e.sb, e.swap, e.nan, e.inf, e.zero);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] x, input logic [63:0] y);
        a       = x;
        b       = y;
        valid_i = 1'b1;
        ce      = 1'b1;
        exp_q.push_back(model(x, y));
        step();
        valid_i = 1'b0;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        ce      = 1'b0;
        valid_i = 1'b1;
        a       = 64'hDEADBEEF01234567;
        b       = 64'h7FF0000000000000;
        step();
        step();
        checks++;
        if ({valid_o, xo, ma, mb, sa, sb, swap_o, nan_o, inf_o, zero_o} !== '0) begin
            errors++;
            $display("FAIL reset_state: valid_o=%b xo=%h ma=%h mb=%h flags=%b%b%b%b%b%b required all zero",
                     valid_o, xo, ma, mb, sa, sb, swap_o, nan_o, inf_o, zero_o);
        end
        rst     = 1'b0;
        valid_i = 1'b0;
        ce      = 1'b1;
        step();
    endtask

    task automatic test_equal_exp();
        send(ONE, ONE);
        step();
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL latency_early: valid_o=%b after 2 cycles, required 0", valid_o);
        end
        step();
        checks++;
        if (valid_o !== 1'b1) begin
            errors++;
            $display("FAIL latency_3: valid_o=%b after 3 cycles, required 1", valid_o);
        end
        checks++;
        if ({xo, ma, mb, swap_o} !== {11'h3FF, 57'h80000000000000, 57'h80000000000000, 1'b0}) begin
            errors++;
            $display("FAIL equal_exp: xo=%h ma=%h mb=%h swap=%b required 3ff 80000000000000 80000000000000 0",
                     xo, ma, mb, swap_o);
        end
    endtask

    task automatic test_small_shift();
        send(ONE, 64'h3FC0000000000000);
        step();
        step();
        checks++;
        if ({valid_o, xo, mb, swap_o} !== {1'b1, 11'h3FF, 57'h10000000000000, 1'b0}) begin
            errors++;
            $display("FAIL small_shift: valid=%b xo=%h mb=%h swap=%b required 1 3ff 10000000000000 0",
                     valid_o, xo, mb, swap_o);
        end
    endtask

    task automatic test_clamp_swap();
        send(64'h39B0000000000000, 64'hBFF0000000000000);
        step();
        step();
        checks++;
        if ({valid_o, swap_o, ma, mb, sa, sb, xo} !==
            {1'b1, 1'b1, 57'h80000000000000, 57'h1, 1'b1, 1'b0, 11'h3FF}) begin
            errors++;
            $display("FAIL clamp_swap: valid=%b swap=%b ma=%h mb=%h sa=%b sb=%b xo=%h required 1 1 80000000000000 1 1 0 3ff",
                     valid_o, swap_o, ma, mb, sa, sb, xo);
        end
    endtask

    task automatic test_denormal();
        send(64'h0010000000000000, 64'h0000000000000001);
        step();
        step();
        checks++;
`ifdef FP64_ALIGN_DENORMALS_EN
        if ({valid_o, xo, ma, mb, zero_o} !== {1'b1, 11'h001, 57'h80000000000000, 57'h8, 2'b00}) begin
            errors++;
            $display("FAIL denormal: valid=%b xo=%h ma=%h mb=%h zero=%b required 1 001 80000000000000 8 00",
                     valid_o, xo, ma, mb, zero_o);
        end
`else
        if ({valid_o, xo, ma, mb, zero_o} !== {1'b1, 11'h001, 57'h80000000000000, 57'h0, 2'b10}) begin
            errors++;
            $display("FAIL denormal_ftz: valid=%b xo=%h ma=%h mb=%h zero=%b required 1 001 80000000000000 0 10",
                     valid_o, xo, ma, mb, zero_o);
        end
`endif
    endtask

    task automatic test_special();
        send(64'h7FF8000000000000, ONE);
        step();
        step();
        checks++;
        if ({valid_o, nan_o, inf_o, xo, ma, mb, swap_o} !==
            {1'b1, 2'b01, 2'b00, 11'h7FF, 57'hC0000000000000, 57'h80000000000000, 1'b0}) begin
            errors++;
            $display("FAIL special_nan: valid=%b nan=%b inf=%b xo=%h ma=%h mb=%h swap=%b required 1 01 00 7ff c0000000000000 80000000000000 0",
                     valid_o, nan_o, inf_o, xo, ma, mb, swap_o);
        end
        send(ONE, 64'hFFF0000000000000);
        step();
        step();
        checks++;
        if ({valid_o, inf_o, nan_o, xo, mb, swap_o, sa} !==
            {1'b1, 2'b01, 2'b00, 11'h7FF, 57'h80000000000000, 1'b1, 1'b1}) begin
            errors++;
            $display("FAIL special_inf: valid=%b inf=%b nan=%b xo=%h mb=%h swap=%b sa=%b required 1 01 00 7ff 80000000000000 1 1",
                     valid_o, inf_o, nan_o, xo, mb, swap_o, sa);
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] x;
        logic [63:0] y;
        int          ey;
        for (int i = 0; i < 24; i++) begin
            x = {$urandom(), $urandom()};
            y = {$urandom(), $urandom()};
            if ($urandom_range(0, 5) == 0) x[62:52] = 11'd0;
            if ($urandom_range(0, 9) == 0) x[62:52] = 11'h7FF;
            ey = int'(x[62:52]) + int'($urandom_range(0, 140)) - 70;
            if (ey < 0) ey = 0;
            if (ey > 2047) ey = 2047;
            y[62:52] = 11'(ey);
            send(x, y);
        end
        repeat (4) step();
    endtask

    task automatic test_stall();
        send(64'h4000000000000001, 64'h3FE0000000000007);
        send(64'h3F00000000000000, 64'h4010000000000003);
        ce      = 1'b0;
        valid_i = 1'b1;
        a       = 64'h7FF0000000000000;
        b       = 64'h0000000000000000;
        step();
        step();
        send(64'h4340000000000000, 64'h3FF000000000000F);
        send(64'hC000000000000000, 64'h4000000000000000);
        repeat (5) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL stall_drain: %0d results outstanding, required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_midflight();
        send(ONE, 64'h3FC0000000000000);
        send(64'h39B0000000000000, ONE);
        rst = 1'b1;
        ce  = 1'b0;
        exp_q.delete();
        step();
        checks++;
        if ({valid_o, xo, ma, mb, sa, sb, swap_o, nan_o, inf_o, zero_o} !== '0) begin
            errors++;
            $display("FAIL reset_midflight: valid_o=%b xo=%h ma=%h mb=%h required all zero", valid_o, xo, ma, mb);
        end
        rst = 1'b0;
        ce  = 1'b1;
        repeat (3) step();
        checks++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_flush: valid_o=%b with no post-reset input, required 0", valid_o);
        end
        send(64'h4000000000000000, ONE);
        step();
        step();
        checks++;
        if ({valid_o, xo, mb} !== {1'b1, 11'h400, 57'h40000000000000}) begin
            errors++;
            $display("FAIL post_reset: valid=%b xo=%h mb=%h required 1 400 40000000000000", valid_o, xo, mb);
        end
    endtask

    initial begin
        rst     = 1'b1;
        ce      = 1'b0;
        valid_i = 1'b0;
        a       = '0;
        b       = '0;
        test_reset();
        test_equal_exp();
        test_small_shift();
        test_clamp_swap();
        test_denormal();
        test_special();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL final_drain: %0d results never produced, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
